// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot loader.
// Build option: CHECKSUM_EN adds a per-section checksum word.
package mips_boot_pkg;

  localparam int unsigned IMEM_AW_DEF = 8;
  localparam int unsigned DMEM_AW_DEF = 5;
  localparam int unsigned DATA_W_DEF  = 32;

  localparam int unsigned HDR_W       = 32;
  localparam int unsigned HDR_COUNT_W = 14;
  localparam int unsigned HDR_BASE_W  = 16;
  localparam int unsigned RANGE_W     = 17;

  localparam int unsigned LAST_BIT  = 31;
  localparam int unsigned TGT_BIT   = 30;
  localparam int unsigned COUNT_MSB = 29;
  localparam int unsigned COUNT_LSB = 16;
  localparam int unsigned BASE_MSB  = 15;
  localparam int unsigned BASE_LSB  = 0;

  localparam logic TGT_IMEM = 1'b0;
  localparam logic TGT_DMEM = 1'b1;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  typedef struct packed {
    logic                   last;
    logic                   tgt;
    logic [HDR_COUNT_W-1:0] count;
    logic [HDR_BASE_W-1:0]  base;
  } hdr_t;

endpackage

// File: rtl/mips_boot_loader_if.sv
// Stream input and memory write bus of the boot loader.
// master = stream source / memory side, slave = loader.
interface mips_boot_loader_if import mips_boot_pkg::*; #(
  parameter int unsigned IMEM_AW = IMEM_AW_DEF,
  parameter int unsigned DMEM_AW = DMEM_AW_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [DATA_W-1:0]  imem_wdata;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/boot_hdr_decode.sv
// Combinational header field extraction and target range check.
module boot_hdr_decode import mips_boot_pkg::*; #(
  parameter int unsigned IMEM_AW = IMEM_AW_DEF,
  parameter int unsigned DMEM_AW = DMEM_AW_DEF
) (
  input  logic [HDR_W-1:0] word_i,
  output hdr_t             hdr_c_o,
  output logic             range_err_c_o
);
  logic [RANGE_W-1:0] end_c;
  logic [RANGE_W-1:0] limit_c;

  // End address is 17 bits wide so BASE+COUNT can never wrap.
  always_comb begin
    hdr_c_o.last  = word_i[LAST_BIT];
    hdr_c_o.tgt   = word_i[TGT_BIT];
    hdr_c_o.count = word_i[COUNT_MSB:COUNT_LSB];
    hdr_c_o.base  = word_i[BASE_MSB:BASE_LSB];
    end_c         = RANGE_W'(hdr_c_o.base) + RANGE_W'(hdr_c_o.count);
    limit_c       = (hdr_c_o.tgt == TGT_DMEM) ? (RANGE_W'(1) << DMEM_AW)
                                              : (RANGE_W'(1) << IMEM_AW);
    range_err_c_o = end_c > limit_c;
  end
endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: writes streamed sections into imem/dmem, then releases the core.
// Build option: CHECKSUM_EN (per-section checksum word, CSUM state).
module mips_boot_loader import mips_boot_pkg::*; #(
  parameter int unsigned IMEM_AW = IMEM_AW_DEF,
  parameter int unsigned DMEM_AW = DMEM_AW_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mips_boot_loader_if.slave   bus,
  output logic                cpu_rst_n,
  output logic                done,
  output logic                err
);
  state_e                 state_q, state_d;
  logic [HDR_BASE_W-1:0]  ptr_q, ptr_d;
  logic [HDR_COUNT_W-1:0] rem_q, rem_d;
  logic                   last_q, last_d;
  logic                   tgt_q, tgt_d;
  logic                   in_ready_q, in_ready_d;
  logic                   imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0]     imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0]      imem_wdata_q, imem_wdata_d;
  logic                   dmem_we_q, dmem_we_d;
  logic [DMEM_AW-1:0]     dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]      dmem_wdata_q, dmem_wdata_d;
  logic                   cpu_rst_n_q, cpu_rst_n_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0]      sum_q, sum_d;
`endif

  hdr_t hdr_c;
  logic range_err_c;
  logic xfer_c;

  boot_hdr_decode #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) u_hdr_decode (
    .word_i        (bus.in_data[HDR_W-1:0]),
    .hdr_c_o       (hdr_c),
    .range_err_c_o (range_err_c)
  );

  assign xfer_c         = bus.in_valid && in_ready_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign cpu_rst_n      = cpu_rst_n_q;
  assign done           = done_q;
  assign err            = err_q;

  // Next state; done/cpu_rst_n follow state_d so they rise with the final write strobe.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    last_d       = last_q;
    tgt_d        = tgt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
`ifdef CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_HDR: begin
        if (xfer_c) begin
          last_d = hdr_c.last;
          tgt_d  = hdr_c.tgt;
          ptr_d  = hdr_c.base;
          rem_d  = hdr_c.count;
`ifdef CHECKSUM_EN
          sum_d  = bus.in_data;
`endif
          if (range_err_c) begin
            state_d = ST_ERR;
          end else if (hdr_c.count != '0) begin
            state_d = ST_DATA;
          end else begin
`ifdef CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = hdr_c.last ? ST_DONE : ST_HDR;
`endif
          end
        end
      end
      ST_DATA: begin
        if (xfer_c) begin
          if (tgt_q == TGT_DMEM) begin
            dmem_we_d    = 1'b1;
            dmem_addr_d  = DMEM_AW'(ptr_q);
            dmem_wdata_d = bus.in_data;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = IMEM_AW'(ptr_q);
            imem_wdata_d = bus.in_data;
          end
          ptr_d = ptr_q + HDR_BASE_W'(1);
          rem_d = rem_q - HDR_COUNT_W'(1);
`ifdef CHECKSUM_EN
          sum_d = sum_q + bus.in_data;
`endif
          if (rem_q == HDR_COUNT_W'(1)) begin
`ifdef CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = last_q ? ST_DONE : ST_HDR;
`endif
          end
        end
      end
`ifdef CHECKSUM_EN
      ST_CSUM: begin
        if (xfer_c) begin
          if (bus.in_data == sum_q) state_d = last_q ? ST_DONE : ST_HDR;
          else                      state_d = ST_ERR;
        end
      end
`endif
      default: ;
    endcase
    in_ready_d  = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    done_d      = (state_d == ST_DONE);
    cpu_rst_n_d = done_d;
    err_d       = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_HDR;
      ptr_q        <= '0;
      rem_q        <= '0;
      last_q       <= 1'b0;
      tgt_q        <= TGT_IMEM;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      cpu_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      last_q       <= last_d;
      tgt_q        <= tgt_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum_q <= '0;
    else        sum_q <= sum_d;
  end
`endif
endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
Upstream boot stage for the single-cycle MIPS core. It accepts a word stream over a valid/ready handshake and writes sections into instruction memory and data memory. It holds the core in reset until the final section has been written, then releases it. This replaces testbench back-door loading of the instruction and data memories with a synthesizable load path.

Parameters:
IMEM_AW, 8, instruction-memory word-address width (256 words)
DMEM_AW, 5, data-memory word-address width (32 words)
DATA_W, 32, stream/memory word width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
in_valid  in  1  stream word valid
in_data  in  DATA_W  stream word
in_ready  out  1  loader accepts word this cycle
imem_we  out  1  instruction-memory write strobe
imem_addr  out  IMEM_AW  instruction-memory word address
imem_wdata  out  DATA_W  instruction word
dmem_we  out  1  data-memory write strobe
dmem_addr  out  DMEM_AW  data-memory word address
dmem_wdata  out  DATA_W  data word
cpu_rst_n  out  1  core reset (active-low), held low while loading
done  out  1  load complete, core running
err  out  1  sticky protocol error

Behaviour:
- Handshake: a word transfers when in_valid && in_ready, sampled on the rising clk edge. in_data is ignored when in_valid is low.
- Header word format:
  - bit31 = LAST
  - bit30 = TGT (0 = imem, 1 = dmem)
  - bits[29:16] = COUNT (words)
  - bits[15:0] = BASE word address
- State machine:
  - HDR: in_ready=1. On transfer, latch LAST, TGT, COUNT, BASE and set ptr=BASE, remaining=COUNT.
    - If BASE+COUNT > 2^AW of the target, go to ERR.
    - Else if COUNT==0, go to HDR (LAST=0) or DONE (LAST=1).
    - Else go to DATA.
  - DATA: in_ready=1. Each transfer writes in_data to ptr on the selected memory, then ptr++ and remaining--.
    - When the final word transfers: go to HDR if LAST=0, else DONE. With CHECKSUM_EN, go to CSUM instead.
  - DONE: in_ready=0, done=1, cpu_rst_n=1. Terminal until reset.
  - ERR: in_ready=0, err=1, cpu_rst_n=0. Terminal until reset.
- Write path is registered:
  - *_we is asserted for exactly one cycle, in the cycle after the accepting edge.
  - addr and wdata are valid in that same cycle.
  - Only the target memory's we asserts. Both we are 0 otherwise.
- cpu_rst_n and done are registered. Both go high on the clock edge at which the last word's write strobe is driven, so the final write and the core release occur in the same cycle. The core leaves reset on the following edge, after the memory has captured the final write.
- Address arithmetic: BASE+COUNT is computed at 17 bits, so it never wraps. ptr never wraps, because the range check guarantees it.
- Reset values (reset low, asynchronous): state=HDR, in_ready=1 (after deassertion), all we=0, addr=0, wdata=0, cpu_rst_n=0, done=0, err=0. A reset mid-section abandons the load; there is no partial resume.
- in_valid held low mid-section: the loader stalls indefinitely and issues no writes.

Optional Feature:
CHECKSUM_EN:
- Defined: after the last data word of each section (and straight after the header when COUNT==0), state CSUM accepts one word.
  - The word must equal the 32-bit wrapping sum of the header plus all data words of the section.
  - Match: continue to HDR or DONE per LAST.
  - Mismatch: go to ERR.
  - Data writes are not retracted on mismatch.
- Undefined: no CSUM state and no sum accumulator. Timing is as above.

Decomposition:
- Shared package `mips_boot_pkg`:
  - state encoding localparams (HDR, DATA, CSUM, DONE, ERR)
  - header field bit positions (LAST_BIT=31, TGT_BIT=30, COUNT_MSB/LSB=29/16, BASE_MSB/LSB=15/0)
  - TGT_IMEM=0, TGT_DMEM=1
- One natural sub-module, `boot_hdr_decode`: combinational header field extraction and range check (target-selected AW). Everything else stays in the top.

Test Plan:
1. Header 0x0003_0000 (imem, count 3, base 0), then 0x21080001 ×3, then header 0xC00C_0000 (last, dmem, count 12, base 0), then words 1,3,5,7,9,2,4,6,8,0,0,0.
   -> imem[0..2] = 0x21080001; dmem[0..11] = 1,3,5,7,9,2,4,6,8,0,0,0; cpu_rst_n and done rise in the cycle dmem[11] is written; err=0.
2. Drop in_valid for 5 cycles mid-section.
   -> no writes occur while in_valid is low; ptr resumes at the correct address; final contents are identical to scenario 1.
3. Header 0xC002_001F (last, dmem, count 2, base 31).
   -> ERR; err=1; cpu_rst_n stays 0; no dmem_we; in_ready=0.
4. Header 0x8000_0010 (last, imem, count 0).
   -> DONE one cycle later; no writes.
5. Assert reset low after 2 data words of a section, then reload scenario 1.
   -> all outputs return to reset values immediately; the reload completes correctly.
6. CHECKSUM_EN: section header 0x8001_0005 with data 0x1 and checksum 0x8001_0006 -> DONE. Same stream with checksum 0x0 -> ERR; imem[5]=0x1 remains written.
